seg_msg_scheduler: RTL and testbench

//  Owns the 8-digit seven-segment display and shares it between the live note/bar readout and

---
 rtl/seg_msg_pkg.sv | 54 +++++
 rtl/seg_char_rom.sv | 43 ++++
 rtl/seg_msg_scheduler.sv | 151 +++++++++++++++
 tb/tb_seg_msg_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_msg_pkg.sv
`default_nettype none
// ============================================================================
// seg_msg_pkg : character codes, request ids, states and 7-seg constants
//               shared by the display scheduler and its character ROM.
// Revision    : 1.0
// ============================================================================
package seg_msg_pkg;

    // Code 0 is blank so callers can zero-suppress; the glyph '0' lives at 10.
    typedef enum logic [4:0] {
        CH_BLANK = 5'd0,
        CH_1     = 5'd1,
        CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
        CH_0,
        CH_A, CH_C, CH_D, CH_E, CH_L, CH_N, CH_O, CH_P, CH_R, CH_S, CH_T, CH_U, CH_Y,
        CH_DASH
    } char_t;

    // Numeric order of SAVE/PLAY/ERR doubles as their priority order.
    typedef enum logic [1:0] {
        REQ_SAVE  = 2'd0,
        REQ_PLAY  = 2'd1,
        REQ_ERR   = 2'd2,
        REQ_CLEAR = 2'd3
    } req_id_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [6:0] SEG_DARK = 7'h7F;

    function automatic char_t banner_char(input req_id_t id, input logic [2:0] idx);
        if (idx[2]) return CH_BLANK;
        case ({id, idx[1:0]})
            {REQ_SAVE, 2'd3}: return CH_S;
            {REQ_SAVE, 2'd2}: return CH_A;
            {REQ_SAVE, 2'd1}: return CH_U;
            {REQ_SAVE, 2'd0}: return CH_E;
            {REQ_PLAY, 2'd3}: return CH_P;
            {REQ_PLAY, 2'd2}: return CH_L;
            {REQ_PLAY, 2'd1}: return CH_A;
            {REQ_PLAY, 2'd0}: return CH_Y;
            {REQ_ERR,  2'd3}: return CH_E;
            {REQ_ERR,  2'd2}: return CH_R;
            {REQ_ERR,  2'd1}: return CH_R;
            {REQ_ERR,  2'd0}: return CH_DASH;
            default:          return CH_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_char_rom.sv
`default_nettype none
// ============================================================================
// seg_char_rom : 5-bit character code -> active-low segments {g,f,e,d,c,b,a}
// Revision     : 1.0
// ============================================================================
module seg_char_rom
    import seg_msg_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_DARK;
        case (code)
            CH_0:    seg = 7'h40;
            CH_1:    seg = 7'h79;
            CH_2:    seg = 7'h24;
            CH_3:    seg = 7'h30;
            CH_4:    seg = 7'h19;
            CH_5:    seg = 7'h12;
            CH_6:    seg = 7'h02;
            CH_7:    seg = 7'h78;
            CH_8:    seg = 7'h00;
            CH_9:    seg = 7'h10;
            CH_A:    seg = 7'h08;
            CH_C:    seg = 7'h46;
            CH_D:    seg = 7'h21;
            CH_E:    seg = 7'h06;
            CH_L:    seg = 7'h47;
            CH_N:    seg = 7'h2B;
            CH_O:    seg = 7'h23;
            CH_P:    seg = 7'h0C;
            CH_R:    seg = 7'h2F;
            CH_S:    seg = 7'h12;
            CH_T:    seg = 7'h07;
            CH_U:    seg = 7'h41;
            CH_Y:    seg = 7'h11;
            CH_DASH: seg = 7'h3F;
            default: seg = SEG_DARK;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/seg_msg_scheduler.sv
`default_nettype none
// ============================================================================
// seg_msg_scheduler : shares the 8-digit display between live view and timed
//                     SAVE/PLAY/ERR banners. Optional macro: SEG_BLINK_EN.
// Revision          : 1.0
// ============================================================================
module seg_msg_scheduler
    import seg_msg_pkg::*;
#(
    parameter int HOLD_CYCLES = 8000000,
    parameter int BLINK_HALF  = 2000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [39:0] iLiveChar,
    input  logic        iReqValid,
    input  logic [1:0]  iReqId,
    output logic        oReqReady,
    output logic [55:0] oSeg,
    output logic        oBannerOn,
    output logic        oBusy
);
    localparam int            CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    state_t        state, state_next;
    req_id_t       req, cur_id, cur_id_next, pend_id, pend_id_next;
    logic          pend_valid, pend_valid_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          expiry, blocked, accept, banner_dark;
    logic [4:0]    code  [8];
    logic [6:0]    glyph [8];
    logic [55:0]   seg_next;

    assign req = req_id_t'(iReqId);

    always_comb begin
        expiry          = (cnt == HOLD_LAST);
        // Only a full slot plus a request that neither preempts, restarts nor overwrites stalls.
        blocked         = (state == ST_SHOW) && pend_valid && (req != REQ_CLEAR)
                          && (req < cur_id) && (req <= pend_id);
        accept          = iReqValid && !blocked;
        state_next      = state;
        cur_id_next     = cur_id;
        cnt_next        = cnt;
        pend_valid_next = pend_valid;
        pend_id_next    = pend_id;
        case (state)
            ST_IDLE: begin
                if (accept && req != REQ_CLEAR) begin
                    state_next  = ST_SHOW;
                    cur_id_next = req;
                    cnt_next    = '0;
                end
            end
            ST_SHOW: begin
                if (accept && req == REQ_CLEAR) begin
                    state_next      = ST_IDLE;
                    cnt_next        = '0;
                    pend_valid_next = 1'b0;
                end else if (accept && (expiry || req >= cur_id)) begin
                    cur_id_next = req;
                    cnt_next    = '0;
                end else if (accept) begin
                    pend_valid_next = 1'b1;
                    pend_id_next    = req;
                end else if (expiry) begin
                    cnt_next = '0;
                    if (pend_valid) begin
                        cur_id_next     = pend_id;
                        pend_valid_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign oReqReady = !blocked;
    assign oBusy     = (state == ST_SHOW) || pend_valid;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state      <= ST_IDLE;
            cur_id     <= REQ_SAVE;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_id    <= REQ_SAVE;
        end else begin
            state      <= state_next;
            cur_id     <= cur_id_next;
            cnt        <= cnt_next;
            pend_valid <= pend_valid_next;
            pend_id    <= pend_id_next;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_dark;

    // Phase restarts lit whenever the hold counter restarts.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            blink_cnt  <= '0;
            blink_dark <= 1'b0;
        end else if (state_next != ST_SHOW || cnt_next == '0) begin
            blink_cnt  <= '0;
            blink_dark <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt  <= '0;
            blink_dark <= !blink_dark;
        end else begin
            blink_cnt  <= blink_cnt + BW'(1);
        end
    end

    assign banner_dark = blink_dark;
`else
    assign banner_dark = 1'b0;
`endif

    for (genvar i = 0; i < 8; i++) begin : g_digit
        assign code[i] = (state == ST_SHOW) ? 5'(banner_char(cur_id, 3'(i)))
                                            : iLiveChar[5*i +: 5];
        seg_char_rom u_rom (
            .code (code[i]),
            .seg  (glyph[i])
        );
        assign seg_next[7*i +: 7] = ((state == ST_SHOW) && banner_dark) ? SEG_DARK : glyph[i];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oSeg      <= {8{SEG_DARK}};
            oBannerOn <= 1'b0;
        end else begin
            oSeg      <= seg_next;
            oBannerOn <= (state == ST_SHOW);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_msg_scheduler.sv
`default_nettype none
// ============================================================================
// tb_seg_msg_scheduler : directed plus random requests against a banner model.
// Revision             : 1.0
// ============================================================================
module tb_seg_msg_scheduler;
    localparam int HOLD  = 16;
    localparam int BLINK = 4;
    localparam logic [55:0] ALL_DARK = {8{7'h7F}};

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [39:0] iLiveChar;
    logic        iReqValid;
    logic [1:0]  iReqId;
    logic        oReqReady;
    logic [55:0] oSeg;
    logic        oBannerOn;
    logic        oBusy;

    int n_cmp = 0;
    int n_bad = 0;

    seg_msg_scheduler #(.HOLD_CYCLES(HOLD), .BLINK_HALF(BLINK)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iLiveChar (iLiveChar),
        .iReqValid (iReqValid),
        .iReqId    (iReqId),
        .oReqReady (oReqReady),
        .oSeg      (oSeg),
        .oBannerOn (oBannerOn),
        .oBusy     (oBusy)
    );

    always #5 iCLK = ~iCLK;

    // Banner model: what is shown, how many cycles it has left, and a one-deep waiting list.
    bit          m_show   = 1'b0;
    int          m_cur    = 0;
    int          m_remain = 0;
    int          m_pend[$];
    logic [55:0] exp_seg  = ALL_DARK;
    logic        exp_on   = 1'b0;

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input byte c);
        case (c)
            8'h30: return 7'h40;  8'h31: return 7'h79;  8'h32: return 7'h24;
            8'h33: return 7'h30;  8'h34: return 7'h19;  8'h35: return 7'h12;
            8'h36: return 7'h02;  8'h37: return 7'h78;  8'h38: return 7'h00;
            8'h39: return 7'h10;  8'h41: return 7'h08;  8'h43: return 7'h46;
            8'h64: return 7'h21;  8'h45: return 7'h06;  8'h4C: return 7'h47;
            8'h6E: return 7'h2B;  8'h6F: return 7'h23;  8'h50: return 7'h0C;
            8'h72: return 7'h2F;  8'h53: return 7'h12;  8'h74: return 7'h07;
            8'h55: return 7'h41;  8'h59: return 7'h11;  8'h2D: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic byte code_char(input int code);
        string letters;
        letters = "ACdELnoPrStUY";
        if (code >= 1 && code <= 9)   return byte'(8'h30 + code);
        if (code == 10)               return 8'h30;
        if (code >= 11 && code <= 23) return letters[code-11];
        if (code == 24)               return 8'h2D;
        return 8'h20;
    endfunction

    function automatic logic [55:0] render();
        logic [55:0] r;
        string       txt;
        r = ALL_DARK;
        if (m_show) begin
            if (m_cur == 0)      txt = "SAUE";
            else if (m_cur == 1) txt = "PLAY";
            else                 txt = "Err-";
            for (int d = 0; d < 4; d++) r[7*d +: 7] = glyph(txt[3-d]);
`ifdef SEG_BLINK_EN
            if ((((HOLD - m_remain) / BLINK) % 2) == 1) r = ALL_DARK;
`endif
        end else begin
            for (int d = 0; d < 8; d++) r[7*d +: 7] = glyph(code_char(int'(iLiveChar[5*d +: 5])));
        end
        return r;
    endfunction

    function automatic bit m_ready(input int id);
        return !(m_show && m_pend.size() > 0 && id != 3 && id < m_cur && id <= m_pend[0]);
    endfunction

    task automatic m_start(input int id);
        m_show   = 1'b1;
        m_cur    = id;
        m_remain = HOLD;
    endtask

    task automatic m_step(input bit v, input int id);
        bit acc, expire;
        acc    = v && m_ready(id);
        expire = (m_remain == 1);
        if (!m_show) begin
            if (acc && id != 3) m_start(id);
        end else if (acc && id == 3) begin
            m_show = 1'b0;
            m_pend.delete();
        end else if (acc && (expire || id >= m_cur)) begin
            m_start(id);
        end else if (acc) begin
            m_pend.delete();
            m_pend.push_back(id);
        end else if (expire) begin
            if (m_pend.size() > 0) m_start(m_pend.pop_front());
            else m_show = 1'b0;
        end else begin
            m_remain--;
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge iCLK);
            #2;
            if (iRST === 1'b1) begin
                check("ready", 56'(oReqReady), 56'(m_ready(int'(iReqId))));
                check("busy",  56'(oBusy),     56'(m_show || m_pend.size() > 0));
            end
            @(posedge iCLK);
            if (iRST !== 1'b1) begin
                m_show = 1'b0;
                m_pend.delete();
                exp_seg = ALL_DARK;
                exp_on  = 1'b0;
            end else begin
                exp_seg = render();
                exp_on  = m_show;
                m_step(iReqValid, int'(iReqId));
            end
            #1;
            check("seg",       oSeg,            exp_seg);
            check("banner_on", 56'(oBannerOn),  56'(exp_on));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge iCLK);
    endtask

    task automatic send(input int id);
        @(negedge iCLK);
        iReqValid = 1'b1;
        iReqId    = 2'(id);
        @(negedge iCLK);
        iReqValid = 1'b0;
    endtask

    initial begin : stimulus
        iRST = 1'b0; iReqValid = 1'b0; iReqId = 2'd0; iLiveChar = '0;
        tick(2);
        #1;
        check("rst_seg",   oSeg,           ALL_DARK);
        check("rst_on",    56'(oBannerOn), 56'(0));
        check("rst_busy",  56'(oBusy),     56'(0));
        check("rst_ready", 56'(oReqReady), 56'(1));
        iLiveChar = 40'h65;
        iRST      = 1'b1;
        tick(1);
        #1;
        check("live_d0",   56'(oSeg[6:0]),  56'(7'h12));
        check("live_d1",   56'(oSeg[13:7]), 56'(7'h30));
        check("live_rest", 56'(oSeg[55:14]), 56'({6{7'h7F}}));
        tick(2);

        send(0);
        tick(1);
        #1;
        check("save_on",   56'(oBannerOn),   56'(1));
        check("save_text", 56'(oSeg[27:0]),  56'({7'h12, 7'h08, 7'h41, 7'h06}));
        check("save_hi",   56'(oSeg[55:28]), 56'({4{7'h7F}}));
        tick(15);
        #1 check("save_last", 56'(oBannerOn), 56'(1));
        tick(1);
        #1 check("save_done", 56'(oBannerOn), 56'(0));
        tick(2);

        send(0);
        tick(3);
        send(1);
        tick(1);
        #1 check("play_text", 56'(oSeg[27:0]), 56'({7'h0C, 7'h47, 7'h08, 7'h11}));
        tick(15);
        #1 check("play_last", 56'(oBannerOn), 56'(1));
        tick(1);
        #1 check("play_done", 56'(oBannerOn), 56'(0));
        tick(2);

        send(1);
        tick(2);
        send(0);
        iReqValid = 1'b1;
        iReqId    = 2'd0;
        #1 check("held_off", 56'(oReqReady), 56'(0));
        @(negedge iCLK);
        iReqValid = 1'b0;
        tick(40);

        send(2);
        tick(1);
        send(3);
        #1 check("clear_busy", 56'(oBusy), 56'(0));
        tick(1);
        #1 check("clear_live", 56'(oBannerOn), 56'(0));
        send(0);
        tick(6);
        #3 iRST = 1'b0;
        #1;
        check("async_rst_seg", oSeg,           ALL_DARK);
        check("async_rst_on",  56'(oBannerOn), 56'(0));
        tick(2);
        iRST = 1'b1;
        tick(2);

`ifdef SEG_BLINK_EN
        send(0);
        tick(1);
        #1 check("blink_lit",  56'(oSeg[27:0]), 56'({7'h12, 7'h08, 7'h41, 7'h06}));
        tick(4);
        #1 check("blink_dark", oSeg, ALL_DARK);
        tick(20);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge iCLK);
            iRST      = ($urandom % 600 != 0);
            iReqValid = ($urandom % 3 == 0);
            iReqId    = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            if ($urandom % 16 == 0) iLiveChar = 40'({$urandom, $urandom});
        end
        @(negedge iCLK);
        iRST = 1'b1;
        iReqValid = 1'b0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
